uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver with an integrated receive FIFO. It is the successor to the fixed 8N1 receiver used by the boot loader and by the SoC benches. It adds configurable data width, parity, stop bits, glitch rejection, error reporting and a show-ahead FIFO read port. It sits between the external rx pin and the program loader or a CPU-mapped UART register block.

Parameters:
BAUD_CYCLE, 868, clock cycles per bit (>=8; 868 = 115200 baud at 100 MHz)
DATA_BITS, 8, data bits per frame (5..8)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked (1 or 2)
FIFO_DEPTH, 16, receive FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx  in  1  serial input, asynchronous, idle high
rdEn  in  1  pop request; ignored while empty
rdData  out  DATA_BITS  FIFO head; valid while empty=0 (show-ahead)
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(FIFO_DEPTH+1)  entries held
dataEn  out  1  1-cycle pulse when a frame is written to the FIFO
frameErr  out  1  1-cycle pulse: a stop bit sampled 0
parityErr  out  1  1-cycle pulse: parity mismatch
overrun  out  1  1-cycle pulse: good frame dropped because the FIFO is full

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst), sampled only on the rising edge of clk.
- Reset: FSM=IDLE, synchroniser flops=1, rdData=0, empty=1, full=0, count=0, all pulses 0, FIFO pointers 0.
- rx passes through a 2-flop synchroniser. All references to rx below mean the synchronised value.
- Baud counter counts 0..BAUD_CYCLE-1 and reloads on every state entry. A bit is sampled when the counter reaches its terminal value.
- FSM:
  - IDLE -> START on the first cycle rx=0.
  - START: waits BAUD_CYCLE/2 cycles (integer division), then samples rx. If 0, go to DATA. If 1, treat as a glitch: return to IDLE with no error.
  - DATA: samples DATA_BITS bits, one per BAUD_CYCLE, LSB first, into a shift register. Goes to PARITY if PARITY_MODE!=0, otherwise to STOP.
  - PARITY: samples one bit. Even mode: XOR of data and parity bit must be 0. Odd mode: it must be 1.
  - STOP: samples STOP_BITS bits, each of which must be 1. After the last stop sample, go to IDLE.
- Frame evaluation happens in the cycle after the last stop sample:
  - Any stop bit sampled 0: frameErr=1 and the frame is discarded. parityErr is also reported if parity was wrong.
  - Otherwise, parity bad: parityErr=1 and the frame is discarded.
  - Otherwise the frame is good. If the FIFO can accept it, write it and pulse dataEn. If not, pulse overrun and drop it.
- A new falling edge is detected immediately after returning to IDLE, so back-to-back frames are received.
- When rx is held low (break), the FSM stays in IDLE after the frameErr until rx returns to 1. This prevents a stream of phantom frames.
- FIFO:
  - A write is accepted if full=0, or if full=1 and rdEn=1 in the same cycle (simultaneous push and pop; count unchanged).
  - Pop with empty=1 has no effect.
  - Simultaneous push and pop when empty: the write lands, the pop is ignored, count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - empty, full and count update in the cycle after the write or pop edge. rdData reflects the new head in the same cycle.
- Latency: from the rx pin falling edge to dataEn is about 2 + BAUD_CYCLE/2 + (DATA_BITS + parity + STOP_BITS) × BAUD_CYCLE + 1 cycles.
- Reset asserted mid-frame aborts the frame. FIFO contents are lost and no error pulse is produced.

Test Plan:
- Basic 8N1 (BAUD_CYCLE=16, defaults otherwise): send 0xA5, 0x3C back-to-back -> two dataEn pulses, count=2, rdData=0xA5; pop once -> rdData=0x3C, count=1.
- Glitch: drive rx low for 4 cycles, then high -> FSM returns to IDLE, no dataEn, no errors. A following frame 0x55 is received correctly.
- Parity (PARITY_MODE=1, DATA_BITS=7): send 0x41 with parity bit 0 -> accepted. Send 0x41 with parity bit 1 -> parityErr pulse, count unchanged.
- Framing (STOP_BITS=2): send 0x81 with second stop bit 0 -> frameErr pulse, frame discarded. Then hold rx low for 3 frame times -> exactly one frameErr, and a frame 0x12 sent after release is received.
- Overrun/wrap (FIFO_DEPTH=4): send 5 frames 0x01..0x05 without popping -> full=1, one overrun pulse on 0x05. Pop 4 -> 0x01..0x04 in order, then empty=1. Send 6 more frames with interleaved pops -> order preserved across the pointer wrap. Pop while full in the same cycle as a write -> count stays 4.
- Reset mid-frame: assert rst during DATA for 1 cycle -> all outputs at reset values and no pulses. The next full frame 0xF0 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, glitch rejection, error
// pulses and a show-ahead receive FIFO.
module uart_rx_fifo #(
  parameter int BAUD_CYCLE  = 868,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx,
  input  logic                              rdEn,
  output logic [DATA_BITS-1:0]              rdData,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              dataEn,
  output logic                              frameErr,
  output logic                              parityErr,
  output logic                              overrun
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_CYCLE);

  localparam logic [BW-1:0] BIT_END  = BW'(BAUD_CYCLE - 1);
  localparam logic [BW-1:0] HALF_END = BW'(BAUD_CYCLE / 2 - 1);
  localparam logic [2:0]    DATA_END = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_END = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state;
  logic                   sync1;
  logic                   sync2;
  logic [BW-1:0]          baud_cnt;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   stop_bad;
  logic                   brk_wait;
  logic                   eval;
  logic                   par_bad;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   push_req;
  logic                   push;
  logic                   pop;

  // Two-flop synchroniser for the asynchronous rx pin; idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  // Frame FSM with the baud counter; it restarts from 0 on every state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_bad <= 1'b0;
      brk_wait <= 1'b0;
      eval     <= 1'b0;
    end else begin
      eval <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (brk_wait) begin
            if (sync2) brk_wait <= 1'b0;
          end else if (!sync2) begin
            state <= START;
          end
        end
        START: begin
          if (baud_cnt == HALF_END) begin
            baud_cnt <= '0;
            state    <= sync2 ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            shreg    <= {sync2, shreg[DATA_BITS-1:1]};
            if (bit_idx == DATA_END) begin
              bit_idx  <= '0;
              stop_bad <= 1'b0;
              state    <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            par_bit  <= sync2;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_END) begin
            baud_cnt <= '0;
            stop_bad <= stop_bad | ~sync2;
            if (bit_idx == STOP_END) begin
              bit_idx  <= '0;
              eval     <= 1'b1;
              brk_wait <= ~sync2;
              state    <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Parity check on the captured frame. shreg, par_bit and stop_bad stay
  // untouched until the next frame reaches DATA (at least half a bit later),
  // so the evaluation cycle reads them directly instead of copying them.
  always_comb begin
    par_bad = 1'b0;
    if (PARITY_MODE == 1)      par_bad = ^{shreg, par_bit};
    else if (PARITY_MODE == 2) par_bad = ~^{shreg, par_bit};
  end

  assign push_req = eval & ~stop_bad & ~par_bad;
  assign push     = push_req & (~full | rdEn);
  assign pop      = rdEn & ~empty;

  // FIFO storage; no reset needed, the head is masked while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy and the registered status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dataEn    <= 1'b0;
      frameErr  <= 1'b0;
      parityErr <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count + CW'(push) - CW'(pop);
      dataEn    <= push;
      frameErr  <= eval & stop_bad;
      parityErr <= eval & par_bad;
      overrun   <= push_req & ~push;
    end
  end

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign rdData = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance (A) and a 7E2 instance (B),
// both at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_fifo;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1, rd_a = 1'b0, rx_b = 1'b1, rd_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       empty_a, full_a, de_a, fe_a, pe_a, ov_a;
  logic       empty_b, full_b, de_b, fe_b, pe_b, ov_b;
  logic [2:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  uart_rx_fifo #(.BAUD_CYCLE(BAUD), .DATA_BITS(8), .PARITY_MODE(0),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rdEn(rd_a), .rdData(data_a),
    .empty(empty_a), .full(full_a), .count(cnt_a), .dataEn(de_a),
    .frameErr(fe_a), .parityErr(pe_a), .overrun(ov_a));

  uart_rx_fifo #(.BAUD_CYCLE(BAUD), .DATA_BITS(7), .PARITY_MODE(1),
                 .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rdEn(rd_b), .rdData(data_b),
    .empty(empty_b), .full(full_b), .count(cnt_b), .dataEn(de_b),
    .frameErr(fe_b), .parityErr(pe_b), .overrun(ov_b));

  int checks = 0;
  int errors = 0;

  // observed pulse counts and model-expected pulse counts, per instance
  int n_de[2] = '{0, 0}, n_fe[2] = '{0, 0}, n_pe[2] = '{0, 0}, n_ov[2] = '{0, 0};
  int e_de[2] = '{0, 0}, e_fe[2] = '{0, 0}, e_pe[2] = '{0, 0}, e_ov[2] = '{0, 0};
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // count pulses on the falling edge, away from the active edge
  always @(negedge clk) begin
    n_de[0] <= n_de[0] + (de_a ? 1 : 0);
    n_fe[0] <= n_fe[0] + (fe_a ? 1 : 0);
    n_pe[0] <= n_pe[0] + (pe_a ? 1 : 0);
    n_ov[0] <= n_ov[0] + (ov_a ? 1 : 0);
    n_de[1] <= n_de[1] + (de_b ? 1 : 0);
    n_fe[1] <= n_fe[1] + (fe_b ? 1 : 0);
    n_pe[1] <= n_pe[1] + (pe_b ? 1 : 0);
    n_ov[1] <= n_ov[1] + (ov_b ? 1 : 0);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dut_cnt(input int d);
    return d != 0 ? int'(cnt_b) : int'(cnt_a);
  endfunction
  function automatic int dut_rd(input int d);
    return d != 0 ? int'(data_b) : int'(data_a);
  endfunction
  function automatic int dut_empty(input int d);
    return d != 0 ? int'(empty_b) : int'(empty_a);
  endfunction
  function automatic int dut_full(input int d);
    return d != 0 ? int'(full_b) : int'(full_a);
  endfunction
  function automatic int qsize(input int d);
    return d != 0 ? q1.size() : q0.size();
  endfunction
  function automatic int qhead(input int d);
    return d != 0 ? int'(q1[0]) : int'(q0[0]);
  endfunction

  task automatic qpush(input int d, input logic [7:0] v);
    if (d != 0) q1.push_back(v);
    else q0.push_back(v);
  endtask
  task automatic qpop(input int d);
    if (d != 0) void'(q1.pop_front());
    else void'(q0.pop_front());
  endtask

  task automatic set_rx(input int d, input logic v);
    if (d != 0) rx_b = v;
    else rx_a = v;
  endtask
  task automatic set_rd(input int d, input logic v);
    if (d != 0) rd_b = v;
    else rd_a = v;
  endtask

  task automatic check_state(input int d, input string tag);
    chk($sformatf("%s[%0d] count", tag, d), dut_cnt(d), qsize(d));
    chk($sformatf("%s[%0d] empty", tag, d), dut_empty(d), qsize(d) == 0 ? 1 : 0);
    chk($sformatf("%s[%0d] full", tag, d), dut_full(d), qsize(d) == DEPTH ? 1 : 0);
    if (qsize(d) > 0) chk($sformatf("%s[%0d] rdData", tag, d), dut_rd(d), qhead(d));
    chk($sformatf("%s[%0d] dataEn pulses", tag, d), n_de[d], e_de[d]);
    chk($sformatf("%s[%0d] frameErr pulses", tag, d), n_fe[d], e_fe[d]);
    chk($sformatf("%s[%0d] parityErr pulses", tag, d), n_pe[d], e_pe[d]);
    chk($sformatf("%s[%0d] overrun pulses", tag, d), n_ov[d], e_ov[d]);
  endtask

  // Send one frame and update the reference model. pop_at >= 0 raises rdEn
  // for the single clock edge pop_at cycles after the start bit is driven.
  task automatic send(input int d, input logic [7:0] data, input logic pbit,
                      input logic [1:0] stops, input int pop_at);
    int         db = (d != 0) ? 7 : 8;
    int         sb = (d != 0) ? 2 : 1;
    logic [7:0] v = (d != 0) ? (data & 8'h7f) : data;
    bit         stop_ok;
    bit         par_ok;
    logic       bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) bits.push_back(v[i]);
    if (d != 0) bits.push_back(pbit);
    for (int i = 0; i < sb; i++) bits.push_back(stops[i]);
    stop_ok = (stops[0] == 1'b1) && (sb == 1 || stops[1] == 1'b1);
    par_ok  = (d == 0) || ((^v) == pbit);
    if (pop_at >= 0 && qsize(d) > 0) begin
      chk("simultaneous pop head", dut_rd(d), qhead(d));
      qpop(d);
    end
    if (!stop_ok) begin
      e_fe[d]++;
      if (!par_ok) e_pe[d]++;
    end else if (!par_ok) begin
      e_pe[d]++;
    end else if (qsize(d) < DEPTH) begin
      qpush(d, v);
      e_de[d]++;
    end else begin
      e_ov[d]++;
    end
    for (int c = 0; c < bits.size() * BAUD; c++) begin
      @(posedge clk);
      #1;
      set_rx(d, bits[c / BAUD]);
      set_rd(d, (c == pop_at - 1) ? 1'b1 : 1'b0);
    end
    set_rd(d, 1'b0);
    if (stops[sb-1] == 1'b0) begin
      set_rx(d, 1'b1);
      repeat (BAUD) @(posedge clk);
      #1;
    end
  endtask

  task automatic pop(input int d, input string tag);
    if (qsize(d) > 0) begin
      chk(tag, dut_rd(d), qhead(d));
      qpop(d);
    end
    @(posedge clk);
    #1;
    set_rd(d, 1'b1);
    @(posedge clk);
    #1;
    set_rd(d, 1'b0);
  endtask

  task automatic drain(input int d, input string tag);
    while (qsize(d) > 0) pop(d, tag);
    pop(d, tag);  // extra pop on empty must be ignored
    check_state(d, tag);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic [1:0] stops;
    int         exp_de;
    int         exp_fe;
    int         exp_pe;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   b_de, b_fe, b_pe;
    logic [7:0] rv;
    logic [1:0] rs;

    tbl[0] = '{8'h41, 1'b0, 2'b11, 1, 0, 0};
    tbl[1] = '{8'h41, 1'b1, 2'b11, 0, 0, 1};
    tbl[2] = '{8'h01, 1'b1, 2'b01, 0, 1, 0};
    tbl[3] = '{8'h55, 1'b1, 2'b10, 0, 1, 1};
    tbl[4] = '{8'h7F, 1'b1, 2'b11, 1, 0, 0};
    tbl[5] = '{8'h00, 1'b0, 2'b11, 1, 0, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset rdData", dut_rd(d), 0);
      check_state(d, "reset");
    end
    rst = 1'b0;

    // back-to-back 8N1 frames
    send(0, 8'hA5, 1'b0, 2'b11, -1);
    send(0, 8'h3C, 1'b0, 2'b11, -1);
    check_state(0, "basic");
    chk("basic head", dut_rd(0), 8'hA5);
    pop(0, "basic pop");
    check_state(0, "basic after pop");
    chk("basic second head", dut_rd(0), 8'h3C);
    drain(0, "basic drain");

    // short low glitch is rejected silently
    @(posedge clk);
    #1 rx_a = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (3 * BAUD) @(posedge clk);
    #1;
    check_state(0, "glitch");
    send(0, 8'h55, 1'b0, 2'b11, -1);
    check_state(0, "after glitch");
    drain(0, "glitch drain");

    // overrun on the fifth frame, then drain in order
    for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 2'b11, -1);
    check_state(0, "overrun");
    drain(0, "overrun drain");

    // interleaved pops across the pointer wrap
    for (int i = 0; i < 6; i++) begin
      send(0, 8'(8'h10 + i), 1'b0, 2'b11, -1);
      if (i % 2 == 1) begin
        pop(0, "wrap pop");
        pop(0, "wrap pop");
      end
      check_state(0, "wrap");
    end
    while (qsize(0) < DEPTH) send(0, 8'($urandom), 1'b0, 2'b11, -1);
    check_state(0, "refill");
    // pop exactly on the write edge of a frame while full
    send(0, 8'h99, 1'b0, 2'b11, BAUD / 2 + 9 * BAUD + 4);
    check_state(0, "push+pop full");
    drain(0, "full drain");

    // randomized 8N1 traffic with occasional bad stop bits
    for (int i = 0; i < 30; i++) begin
      rv = 8'($urandom);
      rs = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b11;
      send(0, rv, 1'b0, rs, -1);
      check_state(0, "rand A");
      repeat ($urandom_range(0, 2)) pop(0, "rand A pop");
    end
    drain(0, "rand A drain");

    // table of 7E2 frames with hand-derived outcomes
    for (int i = 0; i < 6; i++) begin
      b_de = n_de[1];
      b_fe = n_fe[1];
      b_pe = n_pe[1];
      send(1, tbl[i].data, tbl[i].pbit, tbl[i].stops, -1);
      chk($sformatf("vec%0d dataEn", i), n_de[1] - b_de, tbl[i].exp_de);
      chk($sformatf("vec%0d frameErr", i), n_fe[1] - b_fe, tbl[i].exp_fe);
      chk($sformatf("vec%0d parityErr", i), n_pe[1] - b_pe, tbl[i].exp_pe);
      check_state(1, "vec");
    end
    drain(1, "vec drain");

    // break: three frame times low gives exactly one frameErr
    @(posedge clk);
    #1 rx_b = 1'b0;
    repeat (33 * BAUD) @(posedge clk);
    #1 rx_b = 1'b1;
    repeat (2 * BAUD) @(posedge clk);
    #1;
    e_fe[1]++;
    check_state(1, "break");
    send(1, 8'h12, 1'b0, 2'b11, -1);
    check_state(1, "after break");
    drain(1, "break drain");

    // randomized 7E2 traffic with parity and stop faults
    for (int i = 0; i < 20; i++) begin
      rv = 8'($urandom) & 8'h7f;
      rs[0] = ($urandom_range(0, 5) != 0);
      rs[1] = ($urandom_range(0, 5) != 0);
      send(1, rv, (^rv) ^ ($urandom_range(0, 3) == 0), rs, -1);
      check_state(1, "rand B");
      repeat ($urandom_range(0, 2)) pop(1, "rand B pop");
    end

    // reset in the middle of a frame with data held in both FIFOs
    drain(0, "pre-reset drain");
    send(0, 8'h11, 1'b0, 2'b11, -1);
    send(0, 8'h22, 1'b0, 2'b11, -1);
    @(posedge clk);
    #1 rx_a = 1'b0;
    repeat (3 * BAUD) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rx_a = 1'b1;
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      chk("mid reset rdData", dut_rd(d), 0);
      check_state(d, "mid reset");
    end
    repeat (12 * BAUD) @(posedge clk);
    #1;
    check_state(0, "post reset idle");
    check_state(1, "post reset idle");
    send(0, 8'hF0, 1'b0, 2'b11, -1);
    check_state(0, "post reset frame");
    chk("post reset head", dut_rd(0), 8'hF0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
